dct_block_framer: RTL and testbench

- Upstream feeder for the 4-point combinational `dct` block.
- Accepts a serial stream of signed 8-bit samples with a valid/ready handshake.
- Groups the samples into 4-sample blocks in a ping-pong (two-bank) buffer.
- Presents each complete block as a parallel, stable vector with its own valid/ready handshake; this vector drives the dct `in[0..3]` input directly.

---
 rtl/dct_pkg.sv | 25 ++
 rtl/dct_frame_bank.sv | 78 +++++++
 rtl/dct_block_framer.sv | 116 +++++++++++
 tb/tb_dct_block_framer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the 4-point DCT datapath.
//
// The framer only needs the sample/block shapes; the intermediate widths
// are used by the downstream dct stages and are listed here so every
// block in the datapath draws them from one place.
package dct_pkg;

  localparam int DCT_N    = 4;   // samples per transform block
  localparam int SAMPLE_W = 8;   // signed input sample width
  localparam int DIRECT_W = 10;  // forward-transform output width
  localparam int RENORM_W = 13;  // renormalised coefficient width
  localparam int INV_W    = 13;  // inverse-transform output width

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Element k occupies bits [k*SAMPLE_W +: SAMPLE_W]; element 0 is the
  // first sample of the block in arrival order.
  typedef sample_t [DCT_N-1:0] block_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dct_frame_bank.sv
// One bank of the ping-pong block buffer.
//
// Holds N sample registers, the number of valid samples (len), a flag
// recording whether the block was closed early by a flush (padded), and a
// full flag. Samples beyond len read back as zero, so a flushed block is
// zero-padded without ever clearing the sample registers between blocks.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en         write wr_data into sample register wr_idx
//   wr_idx        sample slot being written
//   wr_data       sample value
//   close         mark the bank full with close_len / close_padded
//   close_len     number of valid samples in the closing block
//   close_padded  block was closed by a flush rather than by filling
//   rel           consumer has taken the block; bank becomes empty
//   full          bank holds a complete block awaiting the consumer
//   padded        padded flag of the stored block
//   rd_data       stored block, zero beyond len
module dct_frame_bank
  import dct_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int N = DCT_N
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_idx,
  input  logic [W-1:0]                    wr_data,
  input  logic                            close,
  input  logic [count_w(N)-1:0]           close_len,
  input  logic                            close_padded,
  input  logic                            rel,
  output logic                            full,
  output logic                            padded,
  output logic [N*W-1:0]                  rd_data
);

  localparam int LEN_W = count_w(N);

  logic [W-1:0]     mem [N];
  logic [LEN_W-1:0] len;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the sample registers are deliberately reset; the block must
      // read as all-zero after reset, and clearing them keeps stale data
      // from a discarded block out of any later observation.
      for (int k = 0; k < N; k++) mem[k] <= '0;
      full   <= 1'b0;
      len    <= '0;
      padded <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic, so
      // every register samples the pre-edge values of its neighbours.
      if (wr_en) mem[wr_idx] <= wr_data;
      // A bank is only written/closed while empty and only released while
      // full, so close and rel never apply to the same bank on one edge.
      if (close) begin
        full   <= 1'b1;
        len    <= close_len;
        padded <= close_padded;
      end else if (rel) begin
        full <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch forms.
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(len)) rd_data[k*W +: W] = mem[k];
    end
  end

endmodule

// File: rtl/dct_block_framer.sv
// Upstream feeder for the 4-point dct: groups a serial stream of signed
// samples into N-sample blocks in a two-bank ping-pong buffer and presents
// each complete block as a stable parallel vector.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   s_valid     input sample valid
//   s_ready     framer can accept a sample (a bank is free and not in reset)
//   s_data      signed input sample
//   flush       close the current partial block, zero-padding it
//   m_valid     a complete block is available
//   m_ready     consumer takes the block
//   m_block     block, element k at bits [k*W +: W], k=0 received first
//   m_padded    presented block was closed by flush
//   blk_count   blocks handed off, wrapping modulo 2^CNT_W
module dct_block_framer
  import dct_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int N     = DCT_N,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*W-1:0]   m_block,
  output logic             m_padded,
  output logic [CNT_W-1:0] blk_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int LEN_W = count_w(N);

  logic             wbuf;   // bank being filled
  logic             rbuf;   // bank presented to the consumer
  logic [IDX_W-1:0] widx;   // next slot in the write bank

  logic [1:0]       bank_full;
  logic [1:0]       bank_padded;
  logic [N*W-1:0]   bank_data [2];

  logic             accept;
  logic             last;
  logic             close_full;
  logic             close_flush;
  logic             close;
  logic             handoff;
  logic [LEN_W-1:0] close_len;

  // Both handshake flags come from bank state only; m_ready never reaches
  // s_ready and s_valid never reaches m_valid within a cycle.
  assign s_ready  = !bank_full[wbuf] && !rst;
  assign m_valid  = bank_full[rbuf];

  assign accept   = s_valid && s_ready;
  assign last     = (widx == IDX_W'(N - 1));

  // A flush closes the block only if it holds at least one sample (already
  // written or arriving now) and the block is not closing by itself anyway;
  // a flush while the write bank is unavailable is simply dropped.
  assign close_full  = accept && last;
  assign close_flush = flush && s_ready && ((widx != '0) || accept) && !close_full;
  assign close       = close_full || close_flush;
  assign close_len   = accept ? LEN_W'(widx) + LEN_W'(1) : LEN_W'(widx);

  assign handoff  = m_valid && m_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_frame_bank #(
      .W (W),
      .N (N)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (accept && (wbuf == 1'(b))),
      .wr_idx       (widx),
      .wr_data      (s_data),
      .close        (close && (wbuf == 1'(b))),
      .close_len    (close_len),
      .close_padded (close_flush),
      .rel          (handoff && (rbuf == 1'(b))),
      .full         (bank_full[b]),
      .padded       (bank_padded[b]),
      .rd_data      (bank_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf      <= 1'b0;
      rbuf      <= 1'b0;
      widx      <= '0;
      blk_count <= '0;
    end else begin
      if (close) begin
        wbuf <= !wbuf;
        widx <= '0;
      end else if (accept) begin
        widx <= widx + IDX_W'(1);
      end
      if (handoff) begin
        rbuf      <= !rbuf;
        blk_count <= blk_count + CNT_W'(1);
      end
    end
  end

  assign m_block  = rbuf ? bank_data[1] : bank_data[0];
  assign m_padded = rbuf ? bank_padded[1] : bank_padded[0];

endmodule

// File: tb/tb_dct_block_framer.sv
// Self-checking bench for dct_block_framer.
//
// Expected behaviour comes from a block-level model: a queue of closed
// blocks (at most two may be outstanding) plus a queue of samples of the
// block being assembled. A second instance with a 2-bit counter shares all
// stimulus and is used for the counter-wrap checks.
module tb_dct_block_framer;
  import dct_pkg::*;

  localparam int N = DCT_N;
  localparam int W = SAMPLE_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic [W-1:0] s_data = '0;

  logic           s_ready, m_valid, m_padded;
  logic [N*W-1:0] m_block;
  logic [15:0]    blk_count;
  logic           s_ready2, m_valid2, m_padded2;
  logic [N*W-1:0] m_block2;
  logic [1:0]     blk_count2;

  dct_block_framer #(.W(W), .N(N), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .s_valid (s_valid), .s_ready (s_ready),
    .s_data (s_data), .flush (flush), .m_valid (m_valid), .m_ready (m_ready),
    .m_block (m_block), .m_padded (m_padded), .blk_count (blk_count)
  );

  dct_block_framer #(.W(W), .N(N), .CNT_W(2)) u_dut_wrap (
    .clk (clk), .rst (rst), .s_valid (s_valid), .s_ready (s_ready2),
    .s_data (s_data), .flush (flush), .m_valid (m_valid2), .m_ready (m_ready),
    .m_block (m_block2), .m_padded (m_padded2), .blk_count (blk_count2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    block_t data;
    logic   padded;
  } mblk_t;

  mblk_t       q[$];      // closed blocks awaiting hand-off, oldest first
  sample_t     part[$];   // samples of the block being assembled
  int unsigned count = 0; // blocks handed off

  function automatic block_t blk(input int a, input int b, input int c, input int d);
    block_t r;
    r[0] = sample_t'(a);
    r[1] = sample_t'(b);
    r[2] = sample_t'(c);
    r[3] = sample_t'(d);
    return r;
  endfunction

  task automatic compare_model();
    check("s_ready", 64'(s_ready), 64'(!rst && q.size() < 2));
    check("m_valid", 64'(m_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("m_block", 64'(m_block), 64'(q[0].data));
      check("m_padded", 64'(m_padded), 64'(q[0].padded));
    end
    check("blk_count", 64'(blk_count), 64'(count[15:0]));
    check("blk_count_wrap", 64'(blk_count2), 64'(count[1:0]));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then
  // compare all outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic sv, input logic [W-1:0] d,
                      input logic fl, input logic mr, output bit acc);
    bit    ready, pop;
    mblk_t nb;
    rst = r; s_valid = sv; s_data = d; flush = fl; m_ready = mr;
    ready = !r && (q.size() < 2);
    acc   = sv && ready;
    pop   = !r && (q.size() > 0) && mr;
    @(posedge clk);
    if (r) begin
      q.delete();
      part.delete();
      count = 0;
    end else begin
      if (pop) begin
        q.delete(0);
        count++;
      end
      if (acc) part.push_back(sample_t'(d));
      if (part.size() == N || (fl && ready && part.size() > 0)) begin
        nb.data = '0;
        foreach (part[i]) nb.data[i] = part[i];
        nb.padded = (part.size() < N);
        q.push_back(nb);
        part.delete();
      end
    end
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    bit acc;
    step(1, 0, '0, 0, 0, acc);
    step(1, 0, '0, 0, 0, acc);
  endtask

  // ---------------- directed vector table ----------------
  // Each row drives one cycle; the expected fields describe the outputs
  // just after that cycle's edge. Out-of-range literals such as -147 and
  // 254 are carried as their 8-bit patterns, bit-exact.
  typedef struct {
    logic   r, sv;
    int     d;
    logic   fl, mr;
    logic   esr, emv;
    block_t eblk;
    logic   epad;
    int     ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input logic r, input logic sv, input int d, input logic fl,
                               input logic mr, input logic esr, input logic emv,
                               input block_t eblk, input logic epad, input int ecnt);
    vec_t v;
    v.r = r; v.sv = sv; v.d = d; v.fl = fl; v.mr = mr;
    v.esr = esr; v.emv = emv; v.eblk = eblk; v.epad = epad; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    bit     acc;
    int     nxt;
    int     k;
    bit     hs;
    int     wrap_exp [5] = '{1, 2, 3, 0, 1};
    block_t z;
    z = '0;

    // basic block, latency, flush cases
    vt.push_back(mkv(1, 0, 0,    0, 0, 0, 0, z, 0, 0));
    vt.push_back(mkv(1, 0, 0,    0, 0, 0, 0, z, 0, 0));
    vt.push_back(mkv(0, 1, -147, 0, 1, 1, 0, z, 0, 0));
    vt.push_back(mkv(0, 1, -8,   0, 1, 1, 0, z, 0, 0));
    vt.push_back(mkv(0, 1, 254,  0, 1, 1, 0, z, 0, 0));
    vt.push_back(mkv(0, 1, -40,  0, 1, 1, 1, blk(-147, -8, 254, -40), 0, 0));
    vt.push_back(mkv(0, 0, 0,    0, 1, 1, 0, z, 0, 1));
    vt.push_back(mkv(0, 1, 100,  0, 0, 1, 0, z, 0, 1));
    vt.push_back(mkv(0, 1, -3,   0, 0, 1, 0, z, 0, 1));
    vt.push_back(mkv(0, 0, 0,    1, 0, 1, 1, blk(100, -3, 0, 0), 1, 1));
    vt.push_back(mkv(0, 0, 0,    0, 1, 1, 0, z, 0, 2));
    vt.push_back(mkv(0, 0, 0,    1, 0, 1, 0, z, 0, 2));   // empty flush ignored
    vt.push_back(mkv(0, 0, 0,    0, 0, 1, 0, z, 0, 2));
    vt.push_back(mkv(0, 1, 1,    0, 0, 1, 0, z, 0, 2));
    vt.push_back(mkv(0, 1, 2,    0, 0, 1, 0, z, 0, 2));
    vt.push_back(mkv(0, 1, 3,    0, 0, 1, 0, z, 0, 2));
    vt.push_back(mkv(0, 1, 4,    1, 0, 1, 1, blk(1, 2, 3, 4), 0, 2)); // flush with N-th
    vt.push_back(mkv(0, 0, 0,    0, 1, 1, 0, z, 0, 3));
    vt.push_back(mkv(0, 1, 7,    0, 0, 1, 0, z, 0, 3));
    vt.push_back(mkv(0, 1, 9,    1, 0, 1, 1, blk(7, 9, 0, 0), 1, 3)); // flush with sample
    vt.push_back(mkv(0, 0, 0,    0, 1, 1, 0, z, 0, 4));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].sv, W'(vt[i].d), vt[i].fl, vt[i].mr, acc);
      check($sformatf("tbl%0d_s_ready", i), 64'(s_ready), 64'(vt[i].esr));
      check($sformatf("tbl%0d_m_valid", i), 64'(m_valid), 64'(vt[i].emv));
      if (vt[i].emv) begin
        check($sformatf("tbl%0d_m_block", i), 64'(m_block), 64'(vt[i].eblk));
        check($sformatf("tbl%0d_m_padded", i), 64'(m_padded), 64'(vt[i].epad));
      end
      check($sformatf("tbl%0d_blk_count", i), 64'(blk_count), 64'(vt[i].ecnt));
    end

    // streaming: 12 back-to-back samples, never stalled
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, W'(i), 0, 1, acc);
      check("stream_accept", 64'(acc), 64'(1));
    end
    step(0, 0, '0, 0, 1, acc);
    check("stream_count", 64'(blk_count), 64'(3));

    // backpressure: two banks fill, then one hand-off frees a bank
    do_reset();
    nxt = 1;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, W'(nxt), 0, 0, acc);
      if (acc) nxt++;
    end
    check("bp_accepted", 64'(nxt - 1), 64'(8));
    check("bp_s_ready_low", 64'(s_ready), 64'(0));
    step(0, 1, W'(nxt), 0, 1, acc);
    check("bp_held", 64'(acc), 64'(0));
    check("bp_s_ready_back", 64'(s_ready), 64'(1));
    check("bp_next_block", 64'(m_block), 64'(blk(5, 6, 7, 8)));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, W'(nxt), 0, 0, acc);
      if (acc) nxt++;
    end
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, acc);
    check("bp_drained", 64'(blk_count), 64'(3));

    // reset mid-operation discards a full block and a partial one
    do_reset();
    for (int i = 1; i <= 6; i++) step(0, 1, W'(i), 0, 0, acc);
    step(1, 0, '0, 0, 0, acc);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_blk_count", 64'(blk_count), 64'(0));
    for (int i = 5; i <= 8; i++) step(0, 1, W'(i), 0, 0, acc);
    check("rst_clean_valid", 64'(m_valid), 64'(1));
    check("rst_clean_block", 64'(m_block), 64'(blk(5, 6, 7, 8)));
    check("rst_clean_padded", 64'(m_padded), 64'(0));

    // counter wrap on the 2-bit instance
    do_reset();
    k = 0;
    for (int i = 0; i < 24; i++) begin
      hs = m_valid2;
      step(0, (i < 20), W'(i), 0, 1, acc);
      if (hs && k < 5) begin
        check($sformatf("wrap%0d", k), 64'(blk_count2), 64'(wrap_exp[k]));
        k++;
      end
    end
    check("wrap_handoffs", 64'(k), 64'(5));

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           W'($urandom),
           ($urandom_range(0, 9) == 0),
           ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
